conv_window_buffer: RTL

- Parametrised successor to the fixed 2x2 line-buffer tap FIFO.
- Buffers a raster-order IFM stream and presents a full KERNAL_SIZE x KERNAL_SIZE window of taps.
- Tracks row and column position, applies STRIDE, and flags which windows are valid, so the downstream MAC array consumes only legal windows.
- Sits between the IFM read path and the convolution MAC units in the CU_DP datapath.

---
 rtl/cnn_cu_pkg.sv | 30 +++
 rtl/conv_window_pos_ctrl.sv | 106 ++++++++++
 rtl/conv_window_buffer.sv | 68 ++++++
 3 files changed

// File: rtl/cnn_cu_pkg.sv
// Shared helpers for the CU datapath: pixel type, derived window geometry and tap addressing.
package cnn_cu_pkg;

  localparam int PIXEL_WIDTH = 32;

  typedef logic [PIXEL_WIDTH-1:0] pixel_t;

  // Width of a counter holding 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int fifo_size(input int k, input int ifm);
    return (k - 1) * ifm + k;
  endfunction

  function automatic int out_size(input int k, input int ifm, input int s);
    return (ifm - k) / s + 1;
  endfunction

  function automatic int index_width(input int out_edge);
    return cnt_width(out_edge * out_edge);
  endfunction

  // Shift-register slot holding window row i, column j; slot 0 is the newest pixel.
  function automatic int tap_addr(input int i, input int j, input int k, input int ifm);
    return (k - 1 - i) * ifm + (k - 1 - j);
  endfunction

endpackage

// File: rtl/conv_window_pos_ctrl.sv
// Raster position, stride phase and window/frame pulse generation for conv_window_buffer.
// Defining CONV_WIN_INDEX_EN adds the window_index output.
module conv_window_pos_ctrl
  import cnn_cu_pkg::*;
#(
  parameter int IFM_SIZE    = 32,
  parameter int KERNAL_SIZE = 3,
  parameter int STRIDE      = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic pixel_valid,
  output logic window_valid,
  output logic frame_done
`ifdef CONV_WIN_INDEX_EN
  ,
  output logic [index_width(out_size(KERNAL_SIZE, IFM_SIZE, STRIDE))-1:0] window_index
`endif
);

  localparam int CW = cnt_width(IFM_SIZE);
  localparam int PW = cnt_width(STRIDE);
  localparam logic [CW-1:0] LAST    = CW'(IFM_SIZE - 1);
  localparam logic [CW-1:0] EDGE    = CW'(KERNAL_SIZE - 1);
  localparam logic [PW-1:0] PH_LAST = PW'(STRIDE - 1);

  logic [CW-1:0] col_cnt, col_nxt;
  logic [CW-1:0] row_cnt, row_nxt;
  logic [PW-1:0] col_phase, col_ph_nxt;
  logic [PW-1:0] row_phase, row_ph_nxt;
  logic          hit;
  logic          last_px;

  function automatic logic [PW-1:0] step(input logic [PW-1:0] ph);
    return (ph == PH_LAST) ? '0 : ph + PW'(1);
  endfunction

  // Counters describe the pixel being accepted; the *_nxt values describe the next one.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    col_nxt    = col_cnt;
    row_nxt    = row_cnt;
    col_ph_nxt = col_phase;
    row_ph_nxt = row_phase;
    hit        = (row_cnt >= EDGE) && (col_cnt >= EDGE) &&
                 (row_phase == '0) && (col_phase == '0);
    last_px    = (row_cnt == LAST) && (col_cnt == LAST);
    if (pixel_valid) begin
      if (col_cnt == LAST) begin
        col_nxt    = '0;
        col_ph_nxt = '0;
        if (row_cnt == LAST) begin
          row_nxt    = '0;
          row_ph_nxt = '0;
        end else begin
          row_nxt = row_cnt + CW'(1);
          if (row_cnt >= EDGE) row_ph_nxt = step(row_phase);
        end
      end else begin
        col_nxt = col_cnt + CW'(1);
        if (col_cnt >= EDGE) col_ph_nxt = step(col_phase);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_cnt      <= '0;
      row_cnt      <= '0;
      col_phase    <= '0;
      row_phase    <= '0;
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
    end else if (clear) begin
      col_cnt      <= '0;
      row_cnt      <= '0;
      col_phase    <= '0;
      row_phase    <= '0;
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      col_cnt      <= col_nxt;
      row_cnt      <= row_nxt;
      col_phase    <= col_ph_nxt;
      row_phase    <= row_ph_nxt;
      window_valid <= pixel_valid && hit;
      frame_done   <= pixel_valid && last_px;
    end
  end

`ifdef CONV_WIN_INDEX_EN
  // Holds the raster index of the window being presented; steps once that pulse ends.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      window_index <= '0;
    end else if (clear || frame_done) begin
      window_index <= '0;
    end else if (window_valid) begin
      window_index <= window_index + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/conv_window_buffer.sv
// KxK sliding-window tap buffer over a raster-order IFM stream, with stride-aware valid flags.
// Defining CONV_WIN_INDEX_EN adds the window_index output.
module conv_window_buffer
  import cnn_cu_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int IFM_SIZE    = 32,
  parameter int KERNAL_SIZE = 3,
  parameter int STRIDE      = 1
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      clear,
  input  logic                                      data_valid_in,
  input  logic [DATA_WIDTH-1:0]                     fifo_data_in,
  output logic [KERNAL_SIZE*KERNAL_SIZE*DATA_WIDTH-1:0] window_out,
  output logic                                      window_valid,
  output logic                                      frame_done
`ifdef CONV_WIN_INDEX_EN
  ,
  output logic [index_width(out_size(KERNAL_SIZE, IFM_SIZE, STRIDE))-1:0] window_index
`endif
);

  localparam int FIFO_SIZE = fifo_size(KERNAL_SIZE, IFM_SIZE);

  logic [DATA_WIDTH-1:0] fifo [FIFO_SIZE];
  logic                  shift_en;

  // A simultaneous clear drops the incoming pixel.
  assign shift_en = data_valid_in && !clear;

  // NOTE: the shift register is reset on purpose so the taps read as zero after reset;
  // a plain storage RAM would normally be left unreset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < FIFO_SIZE; n++) fifo[n] <= '0;
    end else if (shift_en) begin
      fifo[0] <= fifo_data_in;
      for (int n = 1; n < FIFO_SIZE; n++) fifo[n] <= fifo[n-1];
    end
  end

  for (genvar i = 0; i < KERNAL_SIZE; i++) begin : g_row
    for (genvar j = 0; j < KERNAL_SIZE; j++) begin : g_col
      localparam int ADDR = tap_addr(i, j, KERNAL_SIZE, IFM_SIZE);
      assign window_out[(i*KERNAL_SIZE+j)*DATA_WIDTH +: DATA_WIDTH] = fifo[ADDR];
    end
  end

  conv_window_pos_ctrl #(
    .IFM_SIZE    (IFM_SIZE),
    .KERNAL_SIZE (KERNAL_SIZE),
    .STRIDE      (STRIDE)
  ) u_pos (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .pixel_valid  (data_valid_in),
    .window_valid (window_valid),
    .frame_done   (frame_done)
`ifdef CONV_WIN_INDEX_EN
    ,
    .window_index (window_index)
`endif
  );

endmodule
